serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 122 ++++++++++++
 tb/tb_serial_frame_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB first,
// even parity bit, stop bit, each held for CLKS_PER_BIT clock cycles.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_nxt;
    logic                parity_q;
    logic                baud_end;
    logic                bit_last;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign shift_nxt = shift_q >> 1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment at the top keeps this block free of latches
    // on paths that do not change state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_valid) state_d = START;
            START:   if (baud_end) state_d = DATA;
            DATA:    if (baud_end && bit_last) state_d = PARITY;
            PARITY:  if (baud_end) state_d = STOP;
            STOP:    if (baud_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state_q == IDLE);
        busy     = !tx_ready;
    end

    // Datapath: the line value for the next bit is registered on the edge that
    // ends the current one, so tx_out changes exactly at bit boundaries.
    // NOTE: the shift register is reset as well, so a frame abandoned by reset
    // leaves no stale payload behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_out   <= 1'b1;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (tx_valid) begin
                    shift_q  <= tx_data;
                    parity_q <= ^tx_data;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_out   <= 1'b0;
                end
            end else if (!baud_end) begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end else begin
                baud_cnt <= '0;
                case (state_q)
                    START: begin
                        tx_out  <= shift_q[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        if (bit_last) begin
                            tx_out <= parity_q;
                        end else begin
                            shift_q <= shift_nxt;
                            tx_out  <= shift_nxt[0];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    PARITY:  tx_out <= 1'b1;
                    STOP:    done   <= 1'b1;
                    default: tx_out <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: default instance plus a
// CLKS_PER_BIT=1 / DATA_W=5 corner instance, checked against a frame model.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;

    logic       tx_valid_a;
    logic [7:0] tx_data_a;
    logic       tx_ready_a, tx_out_a, busy_a, done_a;

    logic       tx_valid_c;
    logic [4:0] tx_data_c;
    logic       tx_ready_c, tx_out_c, busy_c, done_c;

    int total = 0;
    int bad   = 0;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid_a),
        .tx_data  (tx_data_a),
        .tx_ready (tx_ready_a),
        .tx_out   (tx_out_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    serial_frame_tx #(.DATA_W(5), .CLKS_PER_BIT(1)) dut_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid_c),
        .tx_data  (tx_data_c),
        .tx_ready (tx_ready_c),
        .tx_out   (tx_out_c),
        .busy     (busy_c),
        .done     (done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: position 0 is the start bit, 1..w the payload LSB first,
    // w+1 the even parity bit (count of ones modulo 2), w+2 the stop bit.
    function automatic logic exp_bit(input logic [31:0] d, input int w, input int idx);
        int ones;
        if (idx == 0) return 1'b0;
        if (idx <= w) return d[idx-1];
        if (idx == w + 1) begin
            ones = 0;
            for (int k = 0; k < w; k++) ones += int'(d[k]);
            return logic'(ones % 2);
        end
        return 1'b1;
    endfunction

    // Entered at the falling edge right after the accepting edge; returns at
    // the falling edge of the cycle where done should be high.
    task automatic check_frame(input int sel, input logic [31:0] d, input int w, input int c,
                               input int swap_at, input logic [7:0] swap_data);
        for (int i = 0; i < (w + 3) * c; i++) begin
            check($sformatf("line[%0d] d=%0h", i, d), sel ? tx_out_c : tx_out_a, exp_bit(d, w, i / c));
            check($sformatf("busy[%0d]", i), sel ? busy_c : busy_a, 1);
            check($sformatf("done_low[%0d]", i), sel ? done_c : done_a, 0);
            if (i == swap_at) tx_data_a = swap_data;
            @(negedge clk);
        end
        check("done_pulse", sel ? done_c : done_a, 1);
        check("ready_at_done", sel ? tx_ready_c : tx_ready_a, 1);
        check("line_idle_at_done", sel ? tx_out_c : tx_out_a, 1);
    endtask

    task automatic accept_a(input logic [7:0] d, input bit keep);
        check("ready_before_accept", tx_ready_a, 1);
        tx_valid_a = 1'b1;
        tx_data_a  = d;
        @(negedge clk);
        if (!keep) tx_valid_a = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] directed [3];
        directed[0] = 8'h01;
        directed[1] = 8'hFF;
        directed[2] = 8'h00;

        // Reset held with tx_valid high: nothing may start.
        rst_n      = 1'b0;
        tx_valid_a = 1'b1;
        tx_data_a  = 8'hA5;
        tx_valid_c = 1'b0;
        tx_data_c  = 5'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx_out", tx_out_a, 1);
            check("rst_ready", tx_ready_a, 1);
            check("rst_busy", busy_a, 0);
            check("rst_done", done_a, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        check_frame(0, 32'hA5, 8, 4, -1, 8'h00);
        @(negedge clk);
        check("done_one_cycle", done_a, 0);

        // Parity corner words, then random payloads.
        for (int k = 0; k < 3; k++) begin
            accept_a(directed[k], 1'b0);
            check_frame(0, {24'h0, directed[k]}, 8, 4, -1, 8'h00);
            @(negedge clk);
            check("done_drop", done_a, 0);
        end
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            accept_a(d, 1'b0);
            check_frame(0, {24'h0, d}, 8, 4, -1, 8'h00);
            @(negedge clk);
            check("done_drop_rand", done_a, 0);
        end

        // tx_valid held and tx_data changed mid-frame; next word taken at done.
        accept_a(8'h3C, 1'b1);
        check_frame(0, 32'h3C, 8, 4, 10, 8'hC3);
        @(negedge clk);
        tx_valid_a = 1'b0;
        check_frame(0, 32'hC3, 8, 4, -1, 8'h00);
        @(negedge clk);
        check("done_drop_b2b", done_a, 0);

        // Asynchronous reset during data bit 3 (bit 3 forced to 0).
        d = 8'($urandom) & 8'hF7;
        accept_a(d, 1'b0);
        repeat (17) @(negedge clk);
        check("pre_rst_bit3", tx_out_a, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_line", tx_out_a, 1);
        check("async_rst_ready", tx_ready_a, 1);
        check("async_rst_busy", busy_a, 0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check("no_done_after_rst", done_a, 0);
            check("idle_after_rst", tx_out_a, 1);
        end
        accept_a(8'h5A, 1'b0);
        check_frame(0, 32'h5A, 8, 4, -1, 8'h00);
        @(negedge clk);

        // CLKS_PER_BIT=1, DATA_W=5 instance.
        check("c_ready", tx_ready_c, 1);
        tx_valid_c = 1'b1;
        tx_data_c  = 5'b10110;
        @(negedge clk);
        tx_valid_c = 1'b0;
        check_frame(1, 32'h16, 5, 1, -1, 8'h00);
        @(negedge clk);
        check("c_done_drop", done_c, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
